// File: rtl/gpmc_pkg.sv
// Shared GPMC definitions: FSM states, default bus timing and AD width.
// Also imported by the responder-side bench.
package gpmc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WRITE,
    READ,
    TURN
  } gpmc_state_e;

  localparam int GPMC_AD_WIDTH = 16;

  localparam int ADDR_CYC_DEF = 1;
  localparam int WR_CYC_DEF   = 2;
  localparam int RD_LAT_DEF   = 3;
  localparam int TURN_CYC_DEF = 1;

endpackage

// File: rtl/gpmc_phase_gen.sv
// Bus clock phase and per-state bus-cycle counter for the GPMC master.
// Bus state advances only when ph = 1, i.e. at the gpmc_clk falling edge.
module gpmc_phase_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  input  logic [3:0] len,
  output logic       ph,
  output logic       upd,
  output logic       last
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ph  <= 1'b0;
      cnt <= 4'd0;
    end else begin
      ph <= ~ph;
      if (ph)
        cnt <= adv ? 4'd0 : cnt + 4'd1;
    end
  end

  assign upd  = ph;
  assign last = (cnt == len - 4'd1);

endmodule

// File: rtl/gpmc_master.sv
// Synchronous-mode GPMC initiator on a multiplexed 16-bit AD bus.
// Turns single cmd/rsp transactions into address, write or read bus cycles.
module gpmc_master
  import gpmc_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_CYC   = ADDR_CYC_DEF,
  parameter int WR_CYC     = WR_CYC_DEF,
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int TURN_CYC   = TURN_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_we,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [DATA_WIDTH-1:0]    cmd_wdata,
  output logic                     rsp_valid,
  output logic                     rsp_we,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic [GPMC_AD_WIDTH-1:0] gpmc_ad_out,
  output logic                     gpmc_ad_oe,
  input  logic [GPMC_AD_WIDTH-1:0] gpmc_ad_in,
  output logic                     gpmc_advn,
  output logic                     gpmc_csn1,
  output logic                     gpmc_wein,
  output logic                     gpmc_oen,
  output logic                     gpmc_clk
);

  gpmc_state_e state_q, state_d;

  logic ph, upd, last, adv, acc;
  logic [3:0] len;
  logic ready_q, pend_q, done_q, we_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q, cap_q;
  logic [GPMC_AD_WIDTH-1:0] byte_addr;

  gpmc_phase_gen u_phase (
    .clk  (clk),
    .rst  (rst),
    .adv  (adv),
    .len  (len),
    .ph   (ph),
    .upd  (upd),
    .last (last)
  );

  assign gpmc_clk  = ph;
  assign cmd_ready = ready_q;
  assign acc       = cmd_valid && ready_q;
  assign byte_addr = GPMC_AD_WIDTH'({addr_q, 1'b0});
  assign adv       = (state_d != state_q);

  always_comb begin
    len = 4'd1;
    unique case (state_q)
      ADDR:    len = 4'(ADDR_CYC);
      WRITE:   len = 4'(WR_CYC);
      READ:    len = 4'(RD_LAT);
      TURN:    len = 4'(TURN_CYC);
      default: len = 4'd1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (upd && pend_q) state_d = ADDR;
      ADDR:
        if (upd && last) state_d = we_q ? WRITE : READ;
      WRITE, READ:
        if (upd && last) state_d = TURN;
      TURN:
        if (upd && last) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // Bus pins decode straight from the registered state, so they only
  // move on the update edges and are stable at every gpmc_clk rise.
  always_comb begin
    gpmc_csn1   = 1'b1;
    gpmc_advn   = 1'b1;
    gpmc_wein   = 1'b1;
    gpmc_oen    = 1'b1;
    gpmc_ad_oe  = 1'b0;
    gpmc_ad_out = '0;
    unique case (state_q)
      ADDR: begin
        gpmc_csn1   = 1'b0;
        gpmc_advn   = 1'b0;
        gpmc_ad_oe  = 1'b1;
        gpmc_ad_out = byte_addr;
      end
      WRITE: begin
        gpmc_csn1   = 1'b0;
        gpmc_wein   = 1'b0;
        gpmc_ad_oe  = 1'b1;
        gpmc_ad_out = GPMC_AD_WIDTH'(wdata_q);
      end
      READ: begin
        gpmc_csn1 = 1'b0;
        gpmc_oen  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cap_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_q == IDLE) && !pend_q && !acc;
      if (acc) begin
        pend_q  <= 1'b1;
        we_q    <= cmd_we;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end else if (state_q == IDLE && state_d == ADDR) begin
        pend_q <= 1'b0;
      end
      // Sample at the gpmc_clk rise closing the last read cycle
      if (state_q == READ && !ph && last)
        cap_q <= DATA_WIDTH'(gpmc_ad_in);
      done_q    <= (state_q == TURN) && adv;
      rsp_valid <= done_q;
      if (done_q) begin
        rsp_we    <= we_q;
        rsp_rdata <= we_q ? '0 : cap_q;
      end
    end
  end

endmodule

// File: tb/tb_gpmc_master.sv
// Randomized bench for gpmc_master with a GPMC register-file responder
// and a bus timeline reference derived from the cycle-count rules.
module tb_gpmc_master;
  import gpmc_pkg::*;

  localparam int AC = ADDR_CYC_DEF;
  localparam int WC = WR_CYC_DEF;
  localparam int RL = RD_LAT_DEF;
  localparam int TC = TURN_CYC_DEF;

  localparam logic [4:0] V_IDLE  = 5'b11110;
  localparam logic [4:0] V_ADDR  = 5'b00111;
  localparam logic [4:0] V_WRITE = 5'b01011;
  localparam logic [4:0] V_READ  = 5'b01100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [4:0]  cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_we;
  logic [15:0] rsp_rdata;
  logic [15:0] gpmc_ad_out, gpmc_ad_in;
  logic        gpmc_ad_oe, gpmc_advn, gpmc_csn1;
  logic        gpmc_wein, gpmc_oen, gpmc_clk;

  int total = 0;
  int bad   = 0;
  logic mon = 1'b0;
  logic mph;

  logic [15:0] mem [32];
  logic [15:0] ref_mem [32];
  logic [4:0]  ra = '0;
  logic [15:0] junk = '0;
  logic        nx_we;
  logic [4:0]  nx_a;
  logic [15:0] nx_d;
  logic [4:0]  bv;

  always #5 clk = ~clk;

  gpmc_master dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_we      (cmd_we),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_we      (rsp_we),
    .rsp_rdata   (rsp_rdata),
    .gpmc_ad_out (gpmc_ad_out),
    .gpmc_ad_oe  (gpmc_ad_oe),
    .gpmc_ad_in  (gpmc_ad_in),
    .gpmc_advn   (gpmc_advn),
    .gpmc_csn1   (gpmc_csn1),
    .gpmc_wein   (gpmc_wein),
    .gpmc_oen    (gpmc_oen),
    .gpmc_clk    (gpmc_clk)
  );

  assign bv = {gpmc_csn1, gpmc_advn, gpmc_wein, gpmc_oen, gpmc_ad_oe};

  // Register-file responder clocked by the bus clock
  always @(posedge gpmc_clk) begin
    if (!gpmc_csn1 && !gpmc_advn) ra <= gpmc_ad_out[5:1];
    if (!gpmc_csn1 && !gpmc_wein) mem[ra] <= gpmc_ad_out;
  end
  assign gpmc_ad_in = !gpmc_oen ? mem[ra] : junk;

  always @(posedge clk) mph <= rst ? 1'b0 : ~mph;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon) begin
      chk("gclk", gpmc_clk, mph);
      chk("oe_vs_oen", gpmc_ad_oe & ~gpmc_oen, 0);
    end
  end

  function automatic logic [4:0] exp_vec(input int t, input logic we);
    int bc, mid;
    mid = we ? WC : RL;
    if (t < 0) return V_IDLE;
    bc = t / 2;
    if (bc < AC) return V_ADDR;
    if (bc < AC + mid) return we ? V_WRITE : V_READ;
    return V_IDLE;
  endfunction

  task automatic do_rst(input int n);
    rst = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_bus", bv, V_IDLE);
    chk("rst_ad", gpmc_ad_out, 0);
    chk("rst_gclk", gpmc_clk, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_ready", cmd_ready, 0);
    repeat (n - 1) begin
      @(negedge clk);
      chk("rst_ready_hold", cmd_ready, 0);
      chk("rst_rsp_hold", rsp_valid, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("ready_rel", cmd_ready, 1);
    chk("rsp_rel", rsp_valid, 0);
  endtask

  task automatic run_cmd(input logic we, input logic [4:0] a,
                         input logic [15:0] d, input bit hold,
                         input bit b2b, input int abort_at);
    int k, lw, lat, t;
    logic [15:0] exp_rd, ea;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = d;
    k = 0;
    while (!cmd_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("acc_ready", cmd_ready, 1);
    if (b2b) chk("b2b_acc", k, 0);
    lw  = mph ? 2 : 1;
    lat = 2 * (AC + (we ? WC : RL) + TC) + 1;
    exp_rd = we ? 16'h0 : ref_mem[a];
    if (we) ref_mem[a] = d;
    ea = {10'b0, a, 1'b0};
    for (int j = 0; j <= lw + lat; j++) begin
      @(negedge clk);
      t = j - lw;
      junk = 16'($urandom);
      if (j == 0) begin
        chk("ready_drop", cmd_ready, 0);
        cmd_valid = hold;
        cmd_we    = 1'($urandom);
        cmd_addr  = 5'($urandom);
        cmd_wdata = 16'($urandom);
      end else if (!hold) begin
        cmd_valid = (t < lat - 1) ? 1'($urandom) : 1'b0;
      end
      chk("bus", bv, exp_vec(t, we));
      if (bv == V_ADDR) chk("ad_addr", gpmc_ad_out, ea);
      if (bv == V_WRITE) chk("ad_wdata", gpmc_ad_out, d);
      chk("rsp_valid", rsp_valid, t == lat);
      if (t < lat) chk("ready_busy", cmd_ready, 0);
      if (t == lat) begin
        chk("rsp_we", rsp_we, we);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("ready_back", cmd_ready, 1);
        if (hold) begin
          cmd_we    = nx_we;
          cmd_addr  = nx_a;
          cmd_wdata = nx_d;
        end
      end
      if (t == abort_at) begin
        do_rst(3);
        return;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic we;
    logic [4:0] a;
    for (int i = 0; i < 32; i++) begin
      mem[i]     = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    chk("init_bus", bv, V_IDLE);
    chk("init_ad", gpmc_ad_out, 0);
    chk("init_gclk", gpmc_clk, 0);
    chk("init_ready", cmd_ready, 0);
    chk("init_rsp", {rsp_valid, rsp_we, rsp_rdata}, 0);
    mon = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_rel", cmd_ready, 1);

    run_cmd(1'b1, 5'd6, 16'hA5C3, 0, 0, -1);
    run_cmd(1'b1, 5'd2, 16'h1234, 0, 0, -1);
    run_cmd(1'b0, 5'd2, 16'h0, 0, 0, -1);

    nx_we = 1'b0;
    nx_a  = 5'd6;
    nx_d  = 16'h0;
    run_cmd(1'b1, 5'd9, 16'h5A5A, 1, 0, -1);
    run_cmd(1'b0, 5'd6, 16'h0, 0, 1, -1);

    run_cmd(1'b0, 5'd2, 16'h0, 0, 0, 2 * AC + 2);
    run_cmd(1'b0, 5'd2, 16'h0, 0, 0, -1);

    run_cmd(1'b1, 5'd0, 16'h00FF, 0, 0, -1);
    run_cmd(1'b0, 5'd0, 16'h0, 0, 0, -1);

    repeat (40) begin
      we = 1'($urandom);
      a  = 5'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_cmd(we, a, 16'($urandom), 0, 0, -1);
    end

    nx_we = 1'b1;
    nx_a  = 5'd31;
    nx_d  = 16'hBEEF;
    run_cmd(1'b0, 5'd9, 16'h0, 1, 0, -1);
    run_cmd(1'b1, 5'd31, 16'hBEEF, 0, 1, -1);
    run_cmd(1'b0, 5'd31, 16'h0, 0, 0, -1);

    mon = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
